// File: rtl/alu_pipe.sv
// alu_pipe: two-stage signed add/sub/pass ALU with valid/ready handshake, accumulator and optional saturation
module alu_pipe #(
    parameter int WIDTH = 5,
    parameter bit SAT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Din1,
    input  logic [WIDTH-1:0] Din2,
    input  logic [1:0]       Sel,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);
    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             s1_valid, s1_acc, s2_free, s1_adv, take, res_ovf;
    logic [WIDTH-1:0] s1_a, s1_b, acc, res;
    logic [1:0]       s1_sel;
    logic [WIDTH:0]   ea, eb, sum;

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign take     = in_valid && in_ready;

    // Pass ops sign-extend A unchanged, so the overflow test is naturally 0 for them
    always_comb begin
        ea      = {s1_a[WIDTH-1], s1_a};
        eb      = s1_acc ? {acc[WIDTH-1], acc} : {s1_b[WIDTH-1], s1_b};
        sum     = (s1_sel == 2'b00) ? ea + eb : (s1_sel == 2'b11) ? ea - eb : ea;
        res_ovf = sum[WIDTH] != sum[WIDTH-1];
        res     = (SAT && res_ovf) ? (sum[WIDTH] ? MIN : MAX) : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_sel    <= 2'b00;
            s1_acc    <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
            acc       <= '0;
        end else begin
            if (take) begin
                s1_a   <= Din1;
                s1_b   <= Din2;
                s1_sel <= Sel;
                s1_acc <= acc_sel;
            end
            s1_valid  <= take || (s1_valid && !s1_adv);
            out_valid <= s1_adv || (out_valid && !out_ready);
            if (s1_adv) begin
                out <= res;
                ovf <= res_ovf;
            end
            // Clear beats a same-edge write-back; the S2 result already used the old value
            if (acc_clr)
                acc <= '0;
            else if (s1_adv && s1_acc)
                acc <= res;
        end
    end
endmodule
